uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- UART receiver: 8N1 serial input to one byte plus a single-cycle `Rx_done` strobe.
- Sits directly upstream of the debug RAM-loader word assembler, which packs four consecutive bytes MSB-first into a 32-bit RAM write.
- Provides clock-domain synchronisation, start-bit glitch rejection, mid-bit sampling and framing-error detection.

Parameters:
- `CLKS_PER_BIT`, default 434, clk cycles per bit (50 MHz / 115200). Legal range 4..65535.

Ports:
- `clk`, input, 1, system clock.
- `rst`, input, 1, synchronous active-high reset.
- `rx_i`, input, 1, asynchronous serial line; idle high.
- `rx_Data`, output, 8, last correctly framed byte, LSB received first.
- `Rx_done`, output, 1, one-cycle pulse: `rx_Data` holds a new valid byte.
- `frame_err`, output, 1, one-cycle pulse: stop bit sampled low.
- `busy`, output, 1, high while any state other than IDLE is active.

Behaviour:
- Reset: one clock; reset is synchronous and active-high, sampled on the `clk` rising edge.
  - Reset values: `rx_Data`=0, `Rx_done`=0, `frame_err`=0, `busy`=0.
  - Synchroniser flops reset to 1; FSM goes to IDLE; bit counter and cycle counter go to 0.
  - Reset mid-frame abandons the frame with no `Rx_done` or `frame_err` pulse.
- Input path:
  - `rx_i` passes through a 2-flop synchroniser to give `rx_s`.
  - All decisions use `rx_s` only.
- Cycle counter: 16 bits, one shared counter.
- FSM states:
  - IDLE:
    - When `rx_s`=0, go to START and clear the counter.
    - Call this cycle t0.
  - START:
    - The counter counts to (`CLKS_PER_BIT`-1)/2 (integer division), which is the start-bit midpoint.
    - At the midpoint, if `rx_s`=1 the event is a glitch: return to IDLE with no pulses.
    - Otherwise clear the counter and the bit index, then go to DATA.
  - DATA:
    - Every `CLKS_PER_BIT` cycles, sample `rx_s` into shift-register bit[idx], where idx runs 0..7, LSB first.
    - After idx 7 is sampled, go to STOP.
  - STOP:
    - After `CLKS_PER_BIT` cycles, sample `rx_s`.
    - If 1: load `rx_Data` from the shift register, pulse `Rx_done` in the next cycle, go to IDLE.
    - If 0: pulse `frame_err` in the next cycle, leave `rx_Data` unchanged, go to BREAK.
  - BREAK: stay until `rx_s`=1, then go to IDLE. A held-low line never produces repeated errors.
- Sample points: k-th sample (k=0 start, 1..8 data, 9 stop) at t0 + (`CLKS_PER_BIT`-1)/2 + k·`CLKS_PER_BIT`.
- Latency:
  - `Rx_done` rises at stop-sample+1 cycle.
  - `rx_Data` is valid in the same cycle as `Rx_done` and stays stable until the next good frame.
- Back-to-back frames:
  - Returning to IDLE at the stop midpoint allows a start edge arriving half a bit later to be caught.
  - No minimum idle gap is required.
- Pulse exclusivity:
  - `Rx_done` and `frame_err` are never high together.
  - Each is high for exactly one clock per frame.
- Consumer rule: the downstream block samples `rx_Data` only when `Rx_done`=1. There is no backpressure; a byte not taken is overwritten by the next good frame.
- `busy` is a registered decode of state≠IDLE.

Test Plan:
(`CLKS_PER_BIT`=16 in simulation.)
1. Reset held, then released; line idle high for 100 cycles → all outputs 0, `busy`=0, no pulses.
2. Send 0xA5 at 16 cycles/bit → exactly one `Rx_done` pulse, `rx_Data`=0xA5. Pulse is 7+9·16+1+2(sync) cycles after the `rx_i` falling edge; `frame_err` stays 0.
3. Send 0x10, 0x00, 0x00, 0x13 back-to-back with zero idle time → four `Rx_done` pulses, bytes received in order, no lost frames.
4. `rx_i` low glitch of 5 cycles on idle line → returns to IDLE; no `Rx_done`, no `frame_err`; `busy` drops within 8 cycles.
5. Send 0x3C with stop bit forced low, then hold low 200 cycles, release, send 0x7E:
   - one `frame_err` pulse only, with `rx_Data` still at its old value;
   - then `Rx_done` with `rx_Data`=0x7E.
6. Assert `rst` for one cycle during data bit 4 of 0xFF, then send 0x81 → no pulse for the aborted frame; `rx_Data`=0 after reset; next frame gives `rx_Data`=0x81.

Source files
------------

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 UART receiver. It synchronises the serial line, rejects
//            start-bit glitches, samples each bit at its midpoint, and flags
//            framing errors. Each good frame gives one byte and a one-cycle
//            Rx_done strobe.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_Data,
  output logic       Rx_done,
  output logic       frame_err,
  output logic       busy
);

  // The counter is loaded with 1 when a phase begins. A compare against N
  // therefore fires exactly N cycles after the phase-starting edge.
  localparam logic [15:0] C_HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] C_FULL = 16'(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_sync1;
  logic        r_sync2;
  logic        w_rx_s;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        w_cnt_load;
  logic        w_idx_clr;
  logic        w_sample;
  logic        w_done;
  logic        w_ferr;

  assign w_rx_s = r_sync2;

  // Two-flop synchroniser for the asynchronous serial line. It resets to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_cnt_load   = 1'b0;
    w_idx_clr    = 1'b0;
    w_sample     = 1'b0;
    w_done       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = S_START;
          w_cnt_load   = 1'b1;
        end
      end
      S_START: begin
        if (r_cnt == C_HALF) begin
          if (w_rx_s) begin
            w_state_next = S_IDLE;            // line back high: glitch
          end else begin
            w_state_next = S_DATA;
            w_cnt_load   = 1'b1;
            w_idx_clr    = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == C_FULL) begin
          w_sample   = 1'b1;
          w_cnt_load = 1'b1;
          if (r_idx == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == C_FULL) begin
          w_cnt_load = 1'b1;
          if (w_rx_s) begin
            w_done       = 1'b1;
            w_state_next = S_IDLE;            // idle early to catch a back-to-back start
          end else begin
            w_ferr       = 1'b1;
            w_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (w_rx_s) w_state_next = S_IDLE;    // wait out a held-low line silently
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: bit-period counter, bit index, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 16'd0;
      r_idx     <= 3'd0;
      r_shift   <= 8'd0;
      rx_Data   <= 8'd0;
      Rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_cnt <= w_cnt_load ? 16'd1 : r_cnt + 16'd1;
      if (w_idx_clr)     r_idx <= 3'd0;
      else if (w_sample) r_idx <= r_idx + 3'd1;
      if (w_sample) r_shift[r_idx] <= w_rx_s;
      if (w_done)   rx_Data <= r_shift;
      Rx_done   <= w_done;
      frame_err <= w_ferr;
      busy      <= (w_state_next != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_byte
// Brief    : Directed self-checking bench for uart_rx_byte at 16 clocks/bit.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic [7:0] rx_Data;
  logic       Rx_done;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int busy_seen = 0;
  int last_done_cyc = 0;
  int start_cyc = 0;
  logic [7:0] rxq[$];

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .rx_Data   (rx_Data),
    .Rx_done   (Rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycle index: it equals N right after the N-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (Rx_done) begin
      done_cnt++;
      last_done_cyc = cyc;
      rxq.push_back(rx_Data);
    end
    if (frame_err) ferr_cnt++;
    if (Rx_done && frame_err) both_cnt++;
    if (busy) busy_seen++;
  end

  // Hold the line at v for n clock cycles; entered and left 1 time unit after a rising edge.
  task automatic hold_line(input logic v, input int n);
    rx_i = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc;
    hold_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
    hold_line(stop_bit, CPB);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    busy_seen = 0;
    done_cnt = 0;
    ferr_cnt = 0;
    hold_line(1'b1, 100);
    checks++; if (rx_Data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_Data); end
    checks++; if (Rx_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", Rx_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL reset_done_pulses got=%0d exp=0", done_cnt); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL reset_ferr_pulses got=%0d exp=0", ferr_cnt); end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL reset_busy_seen got=%0d exp=0", busy_seen); end
  endtask

  task automatic test_single_byte;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1);
    hold_line(1'b1, 4);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL a5_pulses got=%0d exp=1", done_cnt - d0); end
    checks++; if (rx_Data !== 8'hA5) begin errors++; $display("FAIL a5_data got=%h exp=a5", rx_Data); end
    checks++; if (last_done_cyc - start_cyc !== 154) begin errors++; $display("FAIL a5_latency got=%0d exp=154", last_done_cyc - start_cyc); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL a5_ferr got=%0d exp=0", ferr_cnt - f0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b[4];
    exp_b[0] = 8'h10; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h13;
    rxq.delete();
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1);
    hold_line(1'b1, 20);
    checks++; if (rxq.size() !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", rxq.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rxq.size() || rxq[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d got=%h exp=%h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, exp_b[i]);
      end
    end
  endtask

  task automatic test_glitch;
    int d0, f0;
    logic dropped;
    d0 = done_cnt; f0 = ferr_cnt;
    hold_line(1'b0, 5);
    dropped = 1'b0;
    for (int i = 0; i < 8 && !dropped; i++) begin
      hold_line(1'b1, 1);
      if (busy === 1'b0 && i > 0) dropped = 1'b1;
    end
    checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL glitch_busy_drop got=%b exp=1", dropped); end
    hold_line(1'b1, 200);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL glitch_done got=%0d exp=0", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
  endtask

  task automatic test_frame_error;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    hold_line(1'b0, 200);
    hold_line(1'b1, 16);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL ferr_done got=%0d exp=0", done_cnt - d0); end
    checks++; if (rx_Data !== 8'h13) begin errors++; $display("FAIL ferr_data_kept got=%h exp=13", rx_Data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_after got=%b exp=0", busy); end
    send_frame(8'h7E, 1'b1);
    hold_line(1'b1, 4);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL after_ferr_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (rx_Data !== 8'h7E) begin errors++; $display("FAIL after_ferr_data got=%h exp=7e", rx_Data); end
  endtask

  task automatic test_reset_mid_frame;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    hold_line(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold_line(1'b1, CPB);
    hold_line(1'b1, 8);
    rst = 1'b1;
    hold_line(1'b1, 1);
    rst = 1'b0;
    hold_line(1'b1, 7 + 3 * CPB + CPB + 20);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL abort_ferr got=%0d exp=0", ferr_cnt - f0); end
    checks++; if (rx_Data !== 8'h00) begin errors++; $display("FAIL abort_data got=%h exp=00", rx_Data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    send_frame(8'h81, 1'b1);
    hold_line(1'b1, 4);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL post_abort_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (rx_Data !== 8'h81) begin errors++; $display("FAIL post_abort_data got=%h exp=81", rx_Data); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pulse_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_glitch;
    test_frame_error;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
